// File: rtl/div_pkg.sv
// Shared constants and types for the RV32M iterative divider.
// The DIV_FAST_SPECIAL_EN build option is consumed in rv32m_div_unit.sv.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int ITER  = XLEN;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFFFFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h80000000;

    // Two's-complement negate when neg is set; |INT_MIN| stays 0x80000000 as unsigned.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ({XLEN{1'b0}} - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    // diff[XLEN] set means the trial subtraction borrowed: restore.
    always_comb begin
        rem_out = shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_out = diff[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass CALC.
module rv32m_div_unit
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(ITER);

    // Handshake: start is taken only when busy=0 (IDLE or DONE) and flush=0;
    // done is a single-cycle pulse, and result/tag_out stay valid until the next FIX.

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q, a_q;
    logic [TAG_W-1:0] tag_q;
    op_t              op_q;
    logic             q_neg_q, r_neg_q, div0_q, ovf_q;

    logic             is_signed, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             in_div0, in_ovf, take_fast, accept;
    logic [XLEN-1:0]  step_rem, step_quo;
    logic [XLEN-1:0]  fix_q, fix_r, fix_value;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[XLEN-1];
    assign b_neg     = is_signed & b[XLEN-1];
    assign a_mag     = cond_neg(a, a_neg);
    assign b_mag     = cond_neg(b, b_neg);
    assign in_div0   = (b == '0);
    assign in_ovf    = is_signed & (a == INT_MIN) & (b == '1);

`ifdef DIV_FAST_SPECIAL_EN
    assign take_fast = in_div0 | in_ovf;
`else
    assign take_fast = 1'b0;
`endif

    assign accept    = start & ~flush & ((state == IDLE) | (state == DONE));
    assign busy      = (state == CALC) | (state == FIX);
    assign done      = (state == DONE);
    assign state_dbg = state;

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = accept ? (take_fast ? FIX : CALC) : IDLE;
            CALC:       if (count == CW'(ITER - 1)) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Special cases were latched at start, so the iterated values are ignored for them.
    always_comb begin
        fix_q = cond_neg(quo_q, q_neg_q);
        fix_r = cond_neg(rem_q, r_neg_q);
        if (div0_q) begin
            fix_q = DIV0_Q;
            fix_r = a_q;
        end else if (ovf_q) begin
            fix_q = INT_MIN;
            fix_r = '0;
        end
        fix_value = ((op_q == OP_REM) || (op_q == OP_REMU)) ? fix_r : fix_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            tag_q   <= '0;
            op_q    <= OP_DIV;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            result  <= '0;
            tag_out <= '0;
        end else begin
            if (accept) begin
                count   <= '0;
                rem_q   <= '0;
                quo_q   <= a_mag;
                dvs_q   <= b_mag;
                a_q     <= a;
                tag_q   <= tag_in;
                op_q    <= op_t'(op);
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                div0_q  <= in_div0;
                ovf_q   <= in_ovf;
            end else if (state == CALC) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                count <= count + 1'b1;
            end
            if ((state == FIX) && !flush) begin
                result  <= fix_value;
                tag_out <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: directed cases, randomized ops
// against a plain-arithmetic reference model, reset/flush and back-to-back.
module tb_rv32m_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    rv32m_div_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .tag_in    (tag_in),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .tag_out   (tag_out),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx, sy;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return sx / sy;
            end
            2'b01: return (y == 0) ? 32'hFFFFFFFF : x / y;
            2'b10: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
                return sx % sy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_FAST_SPECIAL_EN
        if (is_special(o, x, y)) return 2;
`endif
        return 34;
    endfunction

    // Counts done pulses over n cycles, sampled 1 time unit after each edge.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    // Issues one op after gap idle negedges; a gap of 0 right after a done
    // lands the start in the DONE cycle (back-to-back).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] t, input int gap, input string name);
        int cyc, busy_cnt, lat;
        lat = exp_latency(o, x, y);
        exp_q.push_back(ref_model(o, x, y));
        repeat (gap) @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; tag_in = t;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; tag_in = 5'($urandom);
        cyc = 1; busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, cyc, lat);
        check({name, " busy_cycles"}, busy_cnt, lat - 1);
        check({name, " result"}, result, exp_q.pop_front());
        check({name, " tag"}, {27'd0, tag_out}, {27'd0, t});
        check({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc, cnt, gap, mode;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        reset_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = 2'b00; a = '0; b = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset tag", {27'd0, tag_out}, 32'd0);
        check("reset state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        run_op(2'b01, 32'd100, 32'd7, 5'd11, 1, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 5'd12, 1, "remu_100_7");
        run_op(2'b00, 32'hFFFFFFF9, 32'd2, 5'd13, 0, "div_m7_2");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 5'd14, 0, "rem_m7_2");
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 5'd15, 2, "rem_7_m2");
        run_op(2'b01, 32'h12345678, 32'd0, 5'd16, 0, "divu_by0");
        run_op(2'b11, 32'h12345678, 32'd0, 5'd17, 0, "remu_by0");
        run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd18, 1, "div_ovf");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd19, 0, "rem_ovf");
        run_op(2'b00, 32'h12345678, 32'd0, 5'd20, 0, "div_by0");
        run_op(2'b10, 32'hF0000001, 32'd0, 5'd21, 0, "rem_neg_by0");
        run_op(2'b01, 32'hFFFFFFFF, 32'd1, 5'd22, 0, "divu_max_1");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 5);
            rx = $urandom;
            ry = $urandom;
            case (mode)
                1: ry = $urandom_range(1, 300);
                2: ry = 32'd0;
                3: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                4: ry = 32'hFFFFFFFF - $urandom_range(0, 5);
                default: ;
            endcase
            gap = $urandom_range(0, 2);
            run_op(ro, rx, ry, 5'($urandom), gap, $sformatf("rand%0d", i));
        end

        // Start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3; tag_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd77; b = 32'd5; tag_in = 5'd3;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("ignore latency", cyc, 34);
        check("ignore result", result, 32'd333);
        check("ignore tag", {27'd0, tag_out}, 32'd9);
        count_done(40, cnt);
        check("ignore no_second_done", cnt, 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3; tag_in = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1;
        check("areset busy", {31'd0, busy}, 32'd0);
        check("areset done", {31'd0, done}, 32'd0);
        check("areset result", result, 32'd0);
        check("areset state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        count_done(40, cnt);
        check("areset no_done", cnt, 0);

        // Flush mid-operation keeps the previous result.
        run_op(2'b01, 32'd100, 32'd7, 5'd6, 1, "pre_flush");
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3; tag_in = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush state", {30'd0, state_dbg}, 32'd0);
        count_done(40, cnt);
        check("flush no_done", cnt, 0);
        check("flush result_kept", result, 32'd14);
        check("flush tag_kept", {27'd0, tag_out}, 32'd6);

        // Flush beats a simultaneous start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5; tag_in = 5'd1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_vs_start busy", {31'd0, busy}, 32'd0);
        count_done(40, cnt);
        check("flush_vs_start no_done", cnt, 0);

        // Back-to-back after the flush checks.
        run_op(2'b00, 32'd1000, 32'hFFFFFFFD, 5'd2, 1, "b2b_op1");
        run_op(2'b10, 32'hFFFFFC18, 32'd7, 5'd3, 0, "b2b_op2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
